prbs_link_monitor: RTL and testbench

Parametrised link-test sequencer and error monitor for the multi-gigabit transceiver PRBS bring-up path. It sequences transceiver reset with timeout and retry, then arms the PRBS checkers. It keeps a saturating error counter per link and scans the links onto the error display and LED bank at a programmable rate. It sits between the transceiver/PRBS checker wrappers and the board LEDs/debug bus, and supports any link count.

---
 rtl/prbs_link_pkg.sv | 21 ++
 rtl/prbs_err_counter.sv | 37 +++
 rtl/prbs_link_monitor.sv | 175 +++++++++++++++++
 tb/tb_prbs_link_monitor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_link_pkg.sv
// prbs_link_pkg: shared types and constants for the PRBS link monitor.
//   link_state_t : link-test sequencer states
//   HEARTBEAT/SEL_LSB/ERR_LSB/ANY_ERR : LED bank bit positions
//   RETRY_W      : width of the saturating GTX retry counter
package prbs_link_pkg;

  typedef enum logic [1:0] {
    RESET_GTX          = 2'd0,
    WAIT_PRBS_START    = 2'd1,
    RESET_PRBS_COUNTER = 2'd2,
    FREE_RUN           = 2'd3
  } link_state_t;

  localparam int HEARTBEAT = 0;
  localparam int SEL_LSB   = 1;
  localparam int ERR_LSB   = 5;
  localparam int ANY_ERR   = 7;

  localparam int RETRY_W   = 8;

endpackage

// File: rtl/prbs_err_counter.sv
// prbs_err_counter: one link's saturating error counter with optional sticky flag.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one error this cycle
//   count    : saturating error count
//   sticky   : set by any inc, cleared by clr (tied 0 when STICKY_EN=0)
module prbs_err_counter #(
  parameter int CNT_W     = 16,
  parameter bit STICKY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sticky
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

  generate
    if (STICKY_EN) begin : g_sticky
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      sticky <= 1'b0;
        else if (clr) sticky <= 1'b0;
        else if (inc) sticky <= 1'b1;
      end
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/prbs_link_monitor.sv
// prbs_link_monitor: transceiver bring-up sequencer and per-link PRBS error monitor.
//   Sequences gtx_reset with timeout/retry, pulses prbs_counter_reset once on
//   prbs_start, then counts errors per link and scans links onto the display/LEDs.
// Ports:
//   clk, rst            : clock, async active-high reset
//   gtx_done            : transceiver up
//   prbs_start          : start PRBS run
//   prbs_error          : NUM_LINKS packed ERR_W error fields
//   clear_counters      : synchronous clear of counters and sticky flags
//   gtx_reset           : transceiver reset request
//   prbs_counter_reset  : one-cycle PRBS checker reset
//   link_sel            : currently displayed link
//   error_display       : registered error field of link_sel
//   err_count_sel       : error counter of link_sel
//   gtx_retries         : saturating retry count
//   led_output          : {any_err, err[1:0], link_sel[3:0], heartbeat}
// Build option: PRBS_LINK_MON_STICKY_EN adds per-link sticky flags that drive
//   led_output[7]; otherwise led_output[7] is the registered OR of prbs_error.
module prbs_link_monitor
  import prbs_link_pkg::*;
#(
  parameter int NUM_LINKS   = 4,
  parameter int ERR_W       = 2,
  parameter int CNT_W       = 16,
  parameter int SCAN_DIV    = 25_000_000,
  parameter int GTX_TIMEOUT = 1_000_000,
  localparam int SEL_W      = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gtx_done,
  input  logic                       prbs_start,
  input  logic [NUM_LINKS*ERR_W-1:0] prbs_error,
  input  logic                       clear_counters,
  output logic                       gtx_reset,
  output logic                       prbs_counter_reset,
  output logic [SEL_W-1:0]           link_sel,
  output logic [ERR_W-1:0]           error_display,
  output logic [CNT_W-1:0]           err_count_sel,
  output logic [RETRY_W-1:0]         gtx_retries,
  output logic [7:0]                 led_output
);

  localparam int TMR_W = $clog2(GTX_TIMEOUT);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GTX_TIMEOUT - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_LINKS - 1);

`ifdef PRBS_LINK_MON_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  link_state_t state, state_d;

  logic [TMR_W-1:0]                  timer;
  logic [PRE_W-1:0]                  presc;
  logic                              heartbeat;
  logic [SEL_W-1:0]                  sel_q;
  logic [RETRY_W-1:0]                retries;
  logic [NUM_LINKS-1:0][ERR_W-1:0]   err_q;
  logic [NUM_LINKS-1:0][CNT_W-1:0]   cnt;
  logic [NUM_LINKS-1:0]              sticky;
  logic [NUM_LINKS-1:0]              inc;
  logic                              clr;
  logic                              tick;
  logic                              timeout_hit;
  logic                              free;
  logic                              any_err;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_GTX;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      RESET_GTX:          if (gtx_done) state_d = WAIT_PRBS_START;
      WAIT_PRBS_START:    if (!gtx_done)      state_d = RESET_GTX;
                          else if (prbs_start) state_d = RESET_PRBS_COUNTER;
      RESET_PRBS_COUNTER: state_d = FREE_RUN;
      FREE_RUN:           if (!gtx_done) state_d = RESET_GTX;
      default:            state_d = RESET_GTX;
    endcase
  end

  // Timeout pulse is decoded from the timer alone so gtx_reset has no input path;
  // the timer only advances in RESET_GTX and is left untouched elsewhere.
  assign timeout_hit = (state == RESET_GTX) && (timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      retries <= '0;
    end else begin
      if (timeout_hit)             timer <= '0;
      else if (state == RESET_GTX) timer <= timer + 1'b1;
      if (timeout_hit && retries != '1) retries <= retries + 1'b1;
    end
  end

  // ---------------- scan prescaler ----------------
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      heartbeat <= 1'b0;
      sel_q     <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) heartbeat <= ~heartbeat;
      // Zeroed on the edge that leaves FREE_RUN so link_sel never shows a stale link.
      if (state_d != FREE_RUN)         sel_q <= '0;
      else if (state == FREE_RUN && tick)
        sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end
  end

  // ---------------- error capture and counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= prbs_error;
  end

  assign free = (state == FREE_RUN);
  assign clr  = clear_counters || (state == RESET_PRBS_COUNTER);

  generate
    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
      assign inc[i] = free && (|prbs_error[i*ERR_W +: ERR_W]);

      prbs_err_counter #(
        .CNT_W     (CNT_W),
        .STICKY_EN (STICKY_EN)
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (inc[i]),
        .count  (cnt[i]),
        .sticky (sticky[i])
      );
    end
  endgenerate

`ifdef PRBS_LINK_MON_STICKY_EN
  assign any_err = |sticky;
`else
  assign any_err = |err_q;
`endif

  // ---------------- outputs ----------------
  assign gtx_reset          = (state == RESET_GTX) && !timeout_hit;
  assign prbs_counter_reset = (state == RESET_PRBS_COUNTER);
  assign gtx_retries        = retries;
  assign link_sel           = sel_q;
  assign error_display      = free ? err_q[sel_q] : '0;
  assign err_count_sel      = free ? cnt[sel_q]   : '0;

  always_comb begin
    led_output = '0;
    if (free) begin
      led_output[HEARTBEAT]        = heartbeat;
      led_output[SEL_LSB +: 4]     = 4'(sel_q);
      led_output[ERR_LSB +: 2]     = 2'(err_q[sel_q]);
      led_output[ANY_ERR]          = any_err;
    end
  end

endmodule

// File: tb/tb_prbs_link_monitor.sv
// tb_prbs_link_monitor: directed bench for prbs_link_monitor with
// NUM_LINKS=3, ERR_W=2, CNT_W=4, SCAN_DIV=4, GTX_TIMEOUT=16.
// Cycle k is the state just after the k-th rising edge following reset release.
module tb_prbs_link_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gtx_done = 1'b0;
  logic       prbs_start = 1'b0;
  logic [5:0] prbs_error = '0;
  logic       clear_counters = 1'b0;
  logic       gtx_reset;
  logic       prbs_counter_reset;
  logic [1:0] link_sel;
  logic [1:0] error_display;
  logic [3:0] err_count_sel;
  logic [7:0] gtx_retries;
  logic [7:0] led_output;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;

`ifdef PRBS_LINK_MON_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  prbs_link_monitor #(
    .NUM_LINKS   (3),
    .ERR_W       (2),
    .CNT_W       (4),
    .SCAN_DIV    (4),
    .GTX_TIMEOUT (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .gtx_done           (gtx_done),
    .prbs_start         (prbs_start),
    .prbs_error         (prbs_error),
    .clear_counters     (clear_counters),
    .gtx_reset          (gtx_reset),
    .prbs_counter_reset (prbs_counter_reset),
    .link_sel           (link_sel),
    .error_display      (error_display),
    .err_count_sel      (err_count_sel),
    .gtx_retries        (gtx_retries),
    .led_output         (led_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gtx_done = 1'b0;
    prbs_start = 1'b0;
    prbs_error = '0;
    clear_counters = 1'b0;
    repeat (3) tick();
    chk("rst_gtx_reset", gtx_reset, 1);
    chk("rst_pcr", prbs_counter_reset, 0);
    chk("rst_link_sel", link_sel, 0);
    chk("rst_err_disp", error_display, 0);
    chk("rst_err_cnt", err_count_sel, 0);
    chk("rst_retries", gtx_retries, 0);
    chk("rst_led", led_output, 0);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // ---------- timeout and retry ----------
    do_reset();
    release_rst();
    for (int k = 1; k <= 50; k++) begin
      run_to(k);
      chk("tmo_gtx_reset", gtx_reset, (k == 15 || k == 31 || k == 47) ? 0 : 1);
    end
    chk("tmo_retries3", gtx_retries, 3);
    run_to(4200);
    chk("tmo_retries_sat", gtx_retries, 255);

    // ---------- bring-up, scan, counters, sticky, link loss ----------
    do_reset();
    release_rst();
    run_to(10);  chk("bu_gtx_reset_hi", gtx_reset, 1);
    gtx_done = 1'b1;
    run_to(11);  chk("bu_gtx_reset_lo", gtx_reset, 0);
                 chk("bu_pcr_idle", prbs_counter_reset, 0);
    run_to(20);  chk("bu_pcr_before", prbs_counter_reset, 0);
    prbs_start = 1'b1;
    run_to(21);  chk("bu_pcr_pulse", prbs_counter_reset, 1);
                 chk("bu_led_rpc", led_output, 8'h00);
    prbs_start = 1'b0;
    run_to(22);  chk("bu_pcr_after", prbs_counter_reset, 0);
                 chk("bu_led_free", led_output, 8'h01);
                 chk("bu_sel0", link_sel, 0);
    run_to(23);  chk("scan_sel23", link_sel, 0);  chk("scan_led23", led_output, 8'h01);
    run_to(24);  chk("scan_sel24", link_sel, 1);  chk("scan_led24", led_output, 8'h02);
    run_to(27);  chk("scan_sel27", link_sel, 1);  chk("scan_led27", led_output, 8'h02);
    run_to(28);  chk("scan_sel28", link_sel, 2);  chk("scan_led28", led_output, 8'h05);
    run_to(32);  chk("scan_sel32", link_sel, 0);  chk("scan_led32", led_output, 8'h00);
    prbs_error = 6'b01_00_00;          // link 2 field = 01
    run_to(36);  chk("sat_sel36", link_sel, 1);   chk("sat_led36", led_output, 8'h83);
    run_to(52);  chk("sat_sel52", link_sel, 2);
                 chk("sat_cnt2", err_count_sel, 15);
                 chk("sat_disp", error_display, 1);
                 chk("sat_led52", led_output, 8'hA5);
    prbs_error = '0;
    run_to(53);  chk("sat_disp0", error_display, 0);
                 chk("sat_cnt2_hold", err_count_sel, 15);
                 chk("sat_led53", led_output, STK ? 8'h85 : 8'h05);
    run_to(56);  chk("sat_sel56", link_sel, 0);   chk("sat_cnt0", err_count_sel, 0);
    run_to(60);  chk("sat_sel60", link_sel, 1);   chk("sat_cnt1", err_count_sel, 0);
    clear_counters = 1'b1;
    prbs_error = 6'b01_00_00;
    run_to(61);  chk("clr_led61", led_output, STK ? 8'h03 : 8'h83);
    clear_counters = 1'b0;
    prbs_error = '0;
    run_to(62);  chk("clr_led62", led_output, 8'h03);
    run_to(64);  chk("clr_sel64", link_sel, 2);   chk("clr_cnt2", err_count_sel, 0);
    prbs_error = 6'b00_10_00;          // single-cycle error on link 1
    run_to(65);  chk("stk_led65", led_output, 8'h84);
    prbs_error = '0;
    run_to(66);  chk("stk_led66", led_output, STK ? 8'h84 : 8'h04);
    run_to(72);  chk("stk_sel72", link_sel, 1);   chk("stk_cnt1", err_count_sel, 1);
                 chk("stk_led72", led_output, STK ? 8'h82 : 8'h02);
    clear_counters = 1'b1;
    run_to(73);  chk("stk_cnt1_clr", err_count_sel, 0);
                 chk("stk_led73", led_output, 8'h02);
    clear_counters = 1'b0;
    gtx_done = 1'b0;                   // link loss
    run_to(74);  chk("loss_gtx_reset", gtx_reset, 1);
                 chk("loss_led", led_output, 0);
                 chk("loss_sel", link_sel, 0);
                 chk("loss_cnt", err_count_sel, 0);
                 chk("loss_disp", error_display, 0);
    gtx_done = 1'b1;
    run_to(75);  chk("wait_gtx_reset", gtx_reset, 0);
    gtx_done = 1'b0;                   // link loss outranks prbs_start
    prbs_start = 1'b1;
    run_to(76);  chk("prio_gtx_reset", gtx_reset, 1);
                 chk("prio_pcr", prbs_counter_reset, 0);
    prbs_start = 1'b0;

    // ---------- asynchronous reset mid-run ----------
    do_reset();
    gtx_done = 1'b1;
    release_rst();
    run_to(1);
    prbs_start = 1'b1;
    run_to(2);   chk("ar_pcr", prbs_counter_reset, 1);
    prbs_start = 1'b0;
    run_to(5);   chk("ar_sel_before", link_sel, 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_sel", link_sel, 0);
    chk("ar_led", led_output, 0);
    chk("ar_gtx_reset", gtx_reset, 1);
    chk("ar_pcr0", prbs_counter_reset, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
